// File: rtl/nv_nvdla_csc_pkg.sv
// ---------------------------------------------------------------------------
// nv_nvdla_csc_pkg
// Shared types and default constants for the CSC accumulator credit tracker.
//   csc_state_e    : layer sequencing state (IDLE / RUN / DRAIN)
//   CSC_CREDIT_MAX : default accumulator assembly-buffer depth
//   CSC_SIZE_W     : width of credit-return and request size fields
//   CSC_STALL_W    : width of the stall performance counter
//   CSC_CNT_W      : credit counter width able to hold CSC_CREDIT_MAX
// ---------------------------------------------------------------------------
package nv_nvdla_csc_pkg;

  localparam int CSC_CREDIT_MAX = 16;
  localparam int CSC_SIZE_W     = 3;
  localparam int CSC_STALL_W    = 16;
  localparam int CSC_CNT_W      = $clog2(CSC_CREDIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } csc_state_e;

endpackage : nv_nvdla_csc_pkg

// File: rtl/nv_nvdla_csc_accu_credit_if.sv
// ---------------------------------------------------------------------------
// nv_nvdla_csc_accu_credit_if
// Bundles the credit-return, layer control, stripe request and status
// signals of the credit tracker.
//   master : stripe issuer / CACC side (drives returns, requests, control)
//   slave  : the credit tracker (drives grant and status)
// ---------------------------------------------------------------------------
interface nv_nvdla_csc_accu_credit_if #(
  parameter int SIZE_W  = nv_nvdla_csc_pkg::CSC_SIZE_W,
  parameter int CNT_W   = nv_nvdla_csc_pkg::CSC_CNT_W,
  parameter int STALL_W = nv_nvdla_csc_pkg::CSC_STALL_W
);

  // credit return from the accumulator
  logic               accu2sc_credit_vld;
  logic [SIZE_W-1:0]  accu2sc_credit_size;
  // layer sequencing
  logic               op_en;
  logic               layer_end;
  // stripe request / grant
  logic               req_vld;
  logic [SIZE_W-1:0]  req_size;
  logic               req_rdy;
  // status
  logic [CNT_W-1:0]   credit_cnt;
  logic               busy;
  logic               drained;
  logic               credit_err;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    output accu2sc_credit_vld, accu2sc_credit_size,
    output op_en, layer_end,
    output req_vld, req_size,
    input  req_rdy,
    input  credit_cnt, busy, drained, credit_err, stall_cnt
  );

  modport slave (
    input  accu2sc_credit_vld, accu2sc_credit_size,
    input  op_en, layer_end,
    input  req_vld, req_size,
    output req_rdy,
    output credit_cnt, busy, drained, credit_err, stall_cnt
  );

endinterface : nv_nvdla_csc_accu_credit_if

// File: rtl/nv_nvdla_sat_cnt.sv
// ---------------------------------------------------------------------------
// nv_nvdla_sat_cnt
// Generic saturating up-counter with synchronous clear.
//   clk   : clock
//   rst   : asynchronous active-high reset (count -> 0)
//   clr_i : synchronous clear, wins over inc_i
//   inc_i : increment by one unless already all-ones
//   cnt_o : current count
// ---------------------------------------------------------------------------
module nv_nvdla_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : nv_nvdla_sat_cnt

// File: rtl/nv_nvdla_csc_accu_credit.sv
// ---------------------------------------------------------------------------
// nv_nvdla_csc_accu_credit
// Tracks free accumulator assembly-buffer entries and gates the CSC stripe
// issuer so CMAC never sends more partial sums than CACC can hold. Also
// sequences layer start / drain, flags credit overflow and counts stalls.
//   nvdla_core_clk : core clock
//   nvdla_core_rst : asynchronous active-high reset
//   ifc (slave)    : credit return, op_en/layer_end, req_vld/req_size/req_rdy,
//                    credit_cnt, busy, drained, credit_err, stall_cnt
// ---------------------------------------------------------------------------
module nv_nvdla_csc_accu_credit
  import nv_nvdla_csc_pkg::*;
#(
  parameter int CREDIT_MAX = CSC_CREDIT_MAX,
  parameter int SIZE_W     = CSC_SIZE_W,
  parameter int CNT_W      = $clog2(CREDIT_MAX + 1),
  parameter int STALL_W    = CSC_STALL_W
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  nv_nvdla_csc_accu_credit_if.slave   ifc
);

  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W + 1)'(CREDIT_MAX);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDIT_MAX);

  csc_state_e       state_q, state_d;
  logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;
  logic             credit_err_q, credit_err_d;
  logic             drained_q, drained_d;

  logic             req_rdy;
  logic             fire;
  logic             start;
  logic             stall_inc;
  logic             overflow;
  logic [CNT_W:0]   ret_ext;
  logic [CNT_W:0]   deb_ext;
  logic [CNT_W:0]   sum;

  // Grant depends only on registered state and count, so a credit returned
  // this cycle is not usable until the next one.
  assign req_rdy   = (state_q == ST_RUN) &&
                     ({1'b0, credit_cnt_q} >= (CNT_W + 1)'(ifc.req_size));
  assign fire      = ifc.req_vld && req_rdy;
  assign start     = (state_q == ST_IDLE) && ifc.op_en;
  assign stall_inc = (state_q == ST_RUN) && ifc.req_vld && !req_rdy;

  // Credit arithmetic, one bit wider than the counter so an over-return is
  // visible before saturation. A debit never exceeds the count, so the
  // subtraction cannot wrap.
  always_comb begin
    ret_ext      = ifc.accu2sc_credit_vld ? (CNT_W + 1)'(ifc.accu2sc_credit_size) : '0;
    deb_ext      = fire ? (CNT_W + 1)'(ifc.req_size) : '0;
    sum          = {1'b0, credit_cnt_q} + ret_ext - deb_ext;
    overflow     = (sum > MAX_EXT);
    credit_cnt_d = overflow ? MAX_CNT : sum[CNT_W-1:0];
    // A new layer clears the sticky error, but an overflow in the same
    // cycle still reports.
    credit_err_d = (credit_err_q && !start) || overflow;
  end

  // NOTE: every signal assigned in this block gets its default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    drained_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ifc.op_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ifc.layer_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Leave once the full credit count is already registered; drained
        // is registered so it lines up with the first IDLE cycle.
        if (credit_cnt_q == MAX_CNT) begin
          state_d   = ST_IDLE;
          drained_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order. The reset is
  // asynchronous so outputs return to idle values before the next edge.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q      <= ST_IDLE;
      credit_cnt_q <= MAX_CNT;
      credit_err_q <= 1'b0;
      drained_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_cnt_q <= credit_cnt_d;
      credit_err_q <= credit_err_d;
      drained_q    <= drained_d;
    end
  end

  logic [STALL_W-1:0] stall_cnt;

  nv_nvdla_sat_cnt #(
    .W (STALL_W)
  ) u_stall_cnt (
    .clk   (nvdla_core_clk),
    .rst   (nvdla_core_rst),
    .clr_i (start),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt)
  );

  assign ifc.req_rdy    = req_rdy;
  assign ifc.credit_cnt = credit_cnt_q;
  assign ifc.busy       = (state_q != ST_IDLE);
  assign ifc.drained    = drained_q;
  assign ifc.credit_err = credit_err_q;
  assign ifc.stall_cnt  = stall_cnt;

endmodule : nv_nvdla_csc_accu_credit

// File: doc/nv_nvdla_csc_accu_credit.md
Name: nv_nvdla_csc_accu_credit

Overview:
- Sits in the convolution sequence controller (CSC), directly upstream of the convolution accumulator.
- Consumes the accumulator's credit-return interface (accu2sc_credit_vld / accu2sc_credit_size).
- Tracks free accumulator assembly-buffer entries and gates the CSC stripe issuer, so CMAC never sends more partial sums than CACC can hold.
- Owns per-layer start/drain sequencing, an overflow-error flag and a stall performance counter.

Parameters:
- CREDIT_MAX, 16, number of accumulator buffer entries; also the credit count after reset and the target for a completed drain.
- SIZE_W, 3, width of the credit-return and request size fields.
- CNT_W, 5, credit counter width; must hold CREDIT_MAX (ceil(log2(CREDIT_MAX+1))).
- STALL_W, 16, width of the stall performance counter.

Ports:
- nvdla_core_clk  in  1  core clock; the block has one clock.
- nvdla_core_rst  in  1  reset; reset is asynchronous and active-high.
- accu2sc_credit_vld  in  1  credit-return strobe from CACC.
- accu2sc_credit_size  in  SIZE_W  entries returned this cycle (0 is legal and has no effect).
- op_en  in  1  layer start pulse.
- layer_end  in  1  pulse marking that the last stripe of the layer has been issued.
- req_vld  in  1  stripe issuer requests credits.
- req_size  in  SIZE_W  entries needed by the stripe.
- req_rdy  out  1  grant; the transfer fires on req_vld & req_rdy.
- credit_cnt  out  CNT_W  current free entries.
- busy  out  1  high in RUN or DRAIN.
- drained  out  1  one-cycle pulse on the DRAIN->IDLE transition.
- credit_err  out  1  sticky flag: a return would have exceeded CREDIT_MAX.
- stall_cnt  out  STALL_W  cycles where req_vld & !req_rdy while in RUN.

Behaviour:
- Reset values:
  - state = IDLE
  - credit_cnt = CREDIT_MAX
  - req_rdy = 0, busy = 0, drained = 0, credit_err = 0, stall_cnt = 0
- Reset asserted mid-operation immediately restores all reset values; any in-flight grant is lost.
- States:
  - IDLE: req_rdy = 0. op_en -> RUN; also clears credit_err and stall_cnt.
  - RUN: req_rdy = (credit_cnt >= req_size), combinational from registered credit_cnt only. layer_end -> DRAIN. op_en is ignored.
  - DRAIN: req_rdy = 0. Moves to IDLE in the cycle after credit_cnt == CREDIT_MAX is registered; drained pulses in that same cycle. op_en and layer_end are ignored.
  - A layer_end in the same cycle as a firing request: the request is granted and debited, then the state goes to DRAIN.
- Counter update each cycle:
  - next = credit_cnt + (accu2sc_credit_vld ? accu2sc_credit_size : 0) - (fire ? req_size : 0)
  - Computed at CNT_W+1 bits.
- Returned credits are not bypassed: they are usable one cycle after accu2sc_credit_vld.
- Simultaneous return and fire both apply in the same cycle.
- Overflow: if next > CREDIT_MAX, credit_cnt saturates to CREDIT_MAX and credit_err sets. credit_err stays set until the next IDLE->RUN op_en.
- Underflow cannot occur because fire requires credit_cnt >= req_size.
- req_size = 0 in RUN: always granted, count unchanged.
- Credit returns are accepted in every state, including IDLE. Returns in IDLE with credit_cnt == CREDIT_MAX and size > 0 set credit_err.
- stall_cnt increments when state == RUN & req_vld & !req_rdy. It saturates at all-ones and holds through DRAIN and IDLE until the next op_en.
- Latency: request to grant is 0 cycles (combinational rdy). Credit return to availability is 1 cycle.

Decomposition:
- Shared package nv_nvdla_csc_pkg holds:
  - state enum (IDLE/RUN/DRAIN, 2-bit encoding)
  - CREDIT_MAX default
  - SIZE_W and STALL_W constants
- One natural sub-module: nv_nvdla_sat_cnt, a generic saturating up-counter with sync clear, used for stall_cnt.
- Credit arithmetic stays inline.

Test Plan:
- Reset then op_en; req_size=5 presented every cycle with no returns -> grants at cycles 1,2,3 (cnt 11,6,1); 4th request stalls with req_rdy=0; stall_cnt increments by 1 per cycle.
- From cnt=1, return size=4 with req_vld, req_size=5 held -> req_rdy rises exactly one cycle after the return; fire brings cnt to 0.
- Same-cycle return size=3 and fire of req_size=2 at cnt=7 -> cnt=8 next cycle; credit_err stays 0.
- At cnt=14, return size=7 -> cnt saturates at 16 and credit_err=1; err persists through DRAIN/IDLE and clears on the next op_en.
- layer_end at cnt=10, then returns of 3 and 3 -> busy stays high; no grants; cnt reaches 16; drained pulses exactly one cycle later; state is IDLE; op_en during DRAIN has no effect.
- Assert nvdla_core_rst mid-RUN at cnt=4 -> cnt=16, req_rdy=0, busy=0 asynchronously, before the next clock edge.
